bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 Parameter ADDR_W, default 30, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter TIMEOUT, default 16, legal range 2..255, SHALL set the maximum number of ACCESS cycles before an abort.
REQ-004 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 rest  in  1  SHALL be the reset, synchronous and active-high.
REQ-006 core_req  in  1  SHALL request one bus transaction; it is sampled only in IDLE.
REQ-007 core_rw  in  1  SHALL select the access type: 0 read, 1 write.
REQ-008 core_addr  in  ADDR_W  SHALL carry the transaction address.
REQ-009 core_wr_data  in  DATA_W  SHALL carry the write data.
REQ-010 core_busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-011 core_rdy  out  1  SHALL be a one-cycle completion pulse.
REQ-012 core_err  out  1  SHALL be a one-cycle timeout-abort pulse, coincident with core_rdy.
REQ-013 core_rd_data  out  DATA_W  SHALL return the read data.
REQ-014 bus_req  out  1  SHALL be the request to the bus arbiter.
REQ-015 bus_grnt  in  1  SHALL be the grant from the bus arbiter.
REQ-016 bus_as  out  1  SHALL be the address strobe, active-high.
REQ-017 bus_rw  out  1  SHALL be the bus access type: 0 read, 1 write.
REQ-018 bus_addr  out  ADDR_W  SHALL be the bus address.
REQ-019 bus_wr_data  out  DATA_W  SHALL be the bus write data.
REQ-020 bus_rd_data  in  DATA_W  SHALL be the bus read data.
REQ-021 bus_rdy  in  1  SHALL be the slave ready, active-high.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, REQ and ACCESS.
REQ-023 IDLE to REQ: when core_req=1, the block SHALL latch core_rw, core_addr and core_wr_data into internal registers.
REQ-024 REQ: bus_req SHALL be 1 and the bus outputs SHALL stay inactive; when bus_grnt=1 the next state SHALL be ACCESS; otherwise the block SHALL wait indefinitely.
REQ-025 ACCESS: bus_req and bus_as SHALL be 1, and bus_rw, bus_addr and bus_wr_data SHALL drive the latched values; bus_grnt SHALL be ignored.
REQ-026 ACCESS with bus_rdy=1 SHALL cause a transition to IDLE, with core_rdy=1 in the following cycle; on a read, core_rd_data SHALL capture bus_rd_data.
REQ-027 On a write, core_rd_data SHALL hold its previous value.
REQ-028 Outside ACCESS, bus_as, bus_rw, bus_addr and bus_wr_data SHALL be 0.
REQ-029 Outside REQ and ACCESS, bus_req SHALL be 0, so it drops for at least one cycle between transactions.
REQ-030 Timeout counter: cleared on entry to ACCESS; increments each ACCESS cycle with bus_rdy=0.
REQ-031 If the timeout counter equals TIMEOUT-1 and bus_rdy=0, the block SHALL abort: next state IDLE, core_rdy=1, core_err=1, core_rd_data=0.
REQ-032 If bus_rdy=1 in the same cycle the timeout would fire, the block SHALL complete normally with core_err=0.
REQ-033 Back-to-back: a core_req in the IDLE cycle in which core_rdy=1 SHALL be accepted.
REQ-034 core_req during REQ or ACCESS SHALL be ignored and not queued.
REQ-035 Minimum latency: core_req at cycle 0 gives bus_req=1 at cycle 1; grant at cycle 1 gives bus_as=1 at cycle 2; bus_rdy at cycle 2 gives core_rdy=1 at cycle 3.
REQ-036 All outputs SHALL be registered or decoded directly from state registers; there SHALL be no combinational path from any input to any output.

Reset
REQ-037 With rest=1 at a clock edge, the next cycle SHALL have state=IDLE and every output at 0, including core_rd_data and the timeout counter.
REQ-038 rest asserted during REQ or ACCESS SHALL abort the transaction with no core_rdy and no core_err pulse.
REQ-039 rest SHALL take priority over all other inputs.

Verification
REQ-040 Read, immediate grant, rdy in the first ACCESS cycle, bus_rd_data=0xDEADBEEF -> core_rdy at cycle 3, core_rd_data=0xDEADBEEF, core_err=0.
REQ-041 Write, addr=0x100, data=0x5A5A5A5A, grant delayed 5 cycles -> bus_req held 5 cycles; bus_as=1 with bus_rw=1, bus_addr=0x100, bus_wr_data=0x5A5A5A5A.
REQ-042 TIMEOUT=16, bus_rdy never asserted -> exactly 16 ACCESS cycles, then core_rdy=1, core_err=1, core_rd_data=0, bus_req=0.
REQ-043 bus_rdy=1 in the 16th ACCESS cycle -> normal completion, core_err=0.
REQ-044 Two back-to-back requests -> bus_req low exactly one cycle between them; the second completes with its own address and data.
REQ-045 rest pulsed mid-ACCESS -> next cycle all outputs 0 and state IDLE; no core_rdy pulse.

Source files
------------

// File: rtl/bus_master_if.sv
// Single-transaction bus master: arbitrates with bus_req/bus_grnt, then runs one strobed access.
// Latency: core_req to core_rdy is 3 cycles minimum; grant wait is unbounded, access aborts after TIMEOUT cycles.
// Backpressure: core_req is sampled only in IDLE and is dropped while busy; the slave stalls via bus_rdy.
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_busy,
  output logic              core_rdy,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              bus_req,
  input  logic              bus_grnt,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req) begin
          rw_d    = core_rw;
          addr_d  = core_addr;
          wdata_d = core_wr_data;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_grnt) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A ready slave wins over a timeout expiring in the same cycle.
        if (bus_rdy) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          if (!rw_q) rdata_d = bus_rd_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs are pure decodes of registered state, so no input reaches an output combinationally.
  assign core_busy    = (state_q != IDLE);
  assign core_rdy     = rdy_q;
  assign core_err     = err_q;
  assign core_rd_data = rdata_q;
  assign bus_req      = (state_q == REQ) || (state_q == ACCESS);
  assign bus_as       = (state_q == ACCESS);
  assign bus_rw       = bus_as & rw_q;
  assign bus_addr     = bus_as ? addr_q : '0;
  assign bus_wr_data  = bus_as ? wdata_q : '0;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: stimulus pushes expected completions, a negedge monitor checks them.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        rest;
  logic        core_req, core_rw;
  logic [29:0] core_addr;
  logic [31:0] core_wr_data;
  logic        core_busy, core_rdy, core_err;
  logic [31:0] core_rd_data;
  logic        bus_req, bus_grnt, bus_as, bus_rw, bus_rdy;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rest(rest),
    .core_req(core_req), .core_rw(core_rw), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_busy(core_busy), .core_rdy(core_rdy),
    .core_err(core_err), .core_rd_data(core_rd_data),
    .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_as(bus_as), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] out_vec();
    return {core_busy, core_rdy, core_err, bus_req, bus_as, bus_rw,
            |core_rd_data, |bus_addr, |bus_wr_data};
  endfunction

  // Monitor: every completion pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (core_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rdy", 64'(core_rdy), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_err", 64'(core_err), 64'(e.err));
          chk("sb_rdata", 64'(core_rd_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    int n;
    exp_t e;
    rest = 1'b1; core_req = 0; core_rw = 0; core_addr = '0; core_wr_data = '0;
    bus_grnt = 0; bus_rdy = 0; bus_rd_data = '0;
    tick(); tick();
    chk("reset_outs", 64'(out_vec()), 64'd0);
    rest = 1'b0;
    tick();

    // Read, immediate grant, ready in first access cycle.
    e.err = 0; e.data = 32'hDEADBEEF; exp_q.push_back(e);
    core_req = 1; core_rw = 0; core_addr = 30'h10;
    bus_grnt = 1; bus_rdy = 1; bus_rd_data = 32'hDEADBEEF;
    tick();
    core_req = 0;
    chk("c1_req_only", 64'({bus_req, bus_as, core_busy}), 64'b101);
    tick();
    chk("c2_access", 64'({bus_as, bus_rw, bus_addr}), {32'd0, 2'b10, 30'h10});
    tick();
    chk("c3_rdy", 64'({core_rdy, core_err, bus_req}), 64'b100);
    bus_grnt = 0; bus_rdy = 0; bus_rd_data = 32'h0BAD0BAD;
    tick();

    // Write with grant delayed five cycles; rd_data must hold.
    e.err = 0; e.data = 32'hDEADBEEF; exp_q.push_back(e);
    core_req = 1; core_rw = 1; core_addr = 30'h100; core_wr_data = 32'h5A5A5A5A;
    tick();
    core_req = 0; core_addr = 30'h3FF; core_wr_data = 32'hFFFFFFFF;
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      if (bus_req && !bus_as) n++;
      if (i == 5) bus_grnt = 1;
      tick();
    end
    chk("req_hold5", 64'(n), 64'd5);
    chk("wr_as_rw", 64'({bus_as, bus_rw}), 64'b11);
    chk("wr_addr", 64'(bus_addr), 64'h100);
    chk("wr_data", 64'(bus_wr_data), 64'h5A5A5A5A);
    bus_grnt = 0; bus_rdy = 1; core_req = 1;
    tick();
    core_req = 0; bus_rdy = 0;
    tick();
    chk("req_not_queued", 64'({core_busy, bus_req}), 64'd0);

    // Timeout: ready never arrives.
    e.err = 1; e.data = 32'h0; exp_q.push_back(e);
    core_req = 1; core_rw = 0; core_addr = 30'h40; bus_grnt = 1;
    tick();
    core_req = 0;
    tick();
    bus_grnt = 0;
    n = 0;
    while (bus_as && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_cycles", 64'(n), 64'd16);
    chk("timeout_outs", 64'({core_rdy, core_err, bus_req, bus_as}), 64'b1100);
    chk("timeout_rdata", 64'(core_rd_data), 64'd0);
    tick();

    // Ready arrives in the sixteenth access cycle.
    e.err = 0; e.data = 32'h12345678; exp_q.push_back(e);
    core_req = 1; core_rw = 0; core_addr = 30'h50; bus_grnt = 1;
    tick();
    core_req = 0;
    tick();
    bus_grnt = 0;
    repeat (15) tick();
    chk("access16_still", 64'(bus_as), 64'd1);
    bus_rdy = 1; bus_rd_data = 32'h12345678;
    tick();
    chk("late_rdy_ok", 64'({core_rdy, core_err}), 64'b10);
    bus_rdy = 0;
    tick();

    // Back-to-back: read then write, second issued in the completion cycle.
    e.err = 0; e.data = 32'h000000A1; exp_q.push_back(e);
    e.err = 0; e.data = 32'h000000A1; exp_q.push_back(e);
    core_req = 1; core_rw = 0; core_addr = 30'h20; bus_grnt = 1; bus_rdy = 1;
    bus_rd_data = 32'h000000A1;
    tick();
    core_req = 0;
    tick();
    chk("b2b_addr1", 64'(bus_addr), 64'h20);
    tick();
    chk("b2b_gap", 64'({core_rdy, bus_req}), 64'b10);
    core_req = 1; core_rw = 1; core_addr = 30'h30; core_wr_data = 32'hCAFEF00D;
    bus_rd_data = 32'hB2B2B2B2;
    tick();
    core_req = 0;
    chk("b2b_req2", 64'(bus_req), 64'd1);
    tick();
    chk("b2b_wr2", 64'({bus_rw, bus_addr, bus_wr_data}), {1'b1, 30'h30, 32'hCAFEF00D});
    tick();
    bus_grnt = 0; bus_rdy = 0;
    tick();

    // Reset in the middle of an access: no completion pulse allowed.
    core_req = 1; core_rw = 1; core_addr = 30'h77; core_wr_data = 32'h11112222; bus_grnt = 1;
    tick();
    core_req = 0;
    tick();
    tick(); tick();
    rest = 1;
    tick();
    rest = 0;
    chk("mid_reset_outs", 64'(out_vec()), 64'd0);
    repeat (4) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
